// File: rtl/duty_phase_limiter.sv
// Duty/phase limiter between silencer and pwm: clamps duty to half the
// transducer cycle, wraps phase into [0, cycle) and keeps per-frame clamp stats.
module duty_phase_limiter #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 249
) (
  input  logic                         CLK_L,
  input  logic                         RST_N,
  input  logic                         TRIG_40KHZ,
  input  logic [DEPTH-1:0][WIDTH-1:0]  CYCLE,
  input  logic                         DIN_VALID,
  input  logic [WIDTH-1:0]             DUTY_IN,
  input  logic [WIDTH-1:0]             PHASE_IN,
  output logic [WIDTH-1:0]             DUTY_OUT,
  output logic [WIDTH-1:0]             PHASE_OUT,
  output logic                         DOUT_VALID,
  output logic                         FRAME_DONE,
  output logic                         FRAME_ERR,
  output logic [15:0]                  CLAMP_CNT
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // input-side beat index
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] eff_idx_c;
  logic             abort_c;

  // S1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_duty_q, s1_duty_d;
  logic [WIDTH-1:0] s1_phase_q, s1_phase_d;
  logic [WIDTH-1:0] s1_cyc_q, s1_cyc_d;
  logic             s1_last_q, s1_last_d;

  // S2 / output registers
  logic             dout_valid_q, dout_valid_d;
  logic [WIDTH-1:0] duty_out_q, duty_out_d;
  logic [WIDTH-1:0] phase_out_q, phase_out_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] clamp_cnt_q, clamp_cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;

  // S2 combinational results
  logic [WIDTH-1:0] half_c;
  logic [WIDTH-1:0] duty_lim_c;
  logic [WIDTH-1:0] phase_wrap_c;
  logic [WIDTH-1:0] phase_diff_c;
  logic             modified_c;
  logic [CNT_W-1:0] acc_inc_c;
  logic [CNT_W-1:0] acc_sum_c;

  // S0: index tracking and trigger resync; a coincident beat becomes index 0
  always_comb begin
    abort_c   = TRIG_40KHZ && (idx_q != '0);
    eff_idx_c = abort_c ? '0 : idx_q;
    idx_d     = eff_idx_c;
    if (DIN_VALID) begin
      idx_d = (eff_idx_c == LAST_IDX) ? '0 : eff_idx_c + IDX_W'(1);
    end
    s1_valid_d = DIN_VALID;
    s1_duty_d  = s1_duty_q;
    s1_phase_d = s1_phase_q;
    s1_cyc_d   = s1_cyc_q;
    s1_last_d  = 1'b0;
    if (DIN_VALID) begin
      s1_duty_d  = DUTY_IN;
      s1_phase_d = PHASE_IN;
      s1_cyc_d   = CYCLE[eff_idx_c];
      s1_last_d  = (eff_idx_c == LAST_IDX);
    end
  end

  // S2: duty clamp and single-step phase wrap
  always_comb begin
    half_c       = s1_cyc_q >> 1;
    phase_diff_c = '0;
    duty_lim_c   = (s1_duty_q < half_c) ? s1_duty_q : half_c;
    phase_wrap_c = s1_phase_q;
    if (s1_phase_q >= s1_cyc_q) begin
      phase_diff_c = s1_phase_q - s1_cyc_q;
      phase_wrap_c = (phase_diff_c < s1_cyc_q) ? phase_diff_c : '0;
    end
    if (s1_cyc_q == '0) begin
      duty_lim_c   = '0;
      phase_wrap_c = '0;
    end
    modified_c = (duty_lim_c != s1_duty_q) || (phase_wrap_c != s1_phase_q);
  end

  // output stage and frame statistics; an abort clear overrides a frame-end load
  always_comb begin
    dout_valid_d = s1_valid_q;
    duty_out_d   = duty_out_q;
    phase_out_d  = phase_out_q;
    frame_done_d = 1'b0;
    frame_err_d  = abort_c;
    clamp_cnt_d  = clamp_cnt_q;
    acc_d        = acc_q;
    acc_inc_c    = (acc_q == '1) ? acc_q : acc_q + CNT_W'(1);
    acc_sum_c    = modified_c ? acc_inc_c : acc_q;
    if (s1_valid_q) begin
      duty_out_d  = duty_lim_c;
      phase_out_d = phase_wrap_c;
      if (s1_last_q) begin
        frame_done_d = 1'b1;
        clamp_cnt_d  = acc_sum_c;
        acc_d        = '0;
      end else begin
        acc_d = acc_sum_c;
      end
    end
    if (abort_c) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge CLK_L or negedge RST_N) begin
    if (!RST_N) begin
      idx_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_duty_q    <= '0;
      s1_phase_q   <= '0;
      s1_cyc_q     <= '0;
      s1_last_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      duty_out_q   <= '0;
      phase_out_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      clamp_cnt_q  <= '0;
      acc_q        <= '0;
    end else begin
      idx_q        <= idx_d;
      s1_valid_q   <= s1_valid_d;
      s1_duty_q    <= s1_duty_d;
      s1_phase_q   <= s1_phase_d;
      s1_cyc_q     <= s1_cyc_d;
      s1_last_q    <= s1_last_d;
      dout_valid_q <= dout_valid_d;
      duty_out_q   <= duty_out_d;
      phase_out_q  <= phase_out_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      clamp_cnt_q  <= clamp_cnt_d;
      acc_q        <= acc_d;
    end
  end

  assign DUTY_OUT   = duty_out_q;
  assign PHASE_OUT  = phase_out_q;
  assign DOUT_VALID = dout_valid_q;
  assign FRAME_DONE = frame_done_q;
  assign FRAME_ERR  = frame_err_q;
  assign CLAMP_CNT  = clamp_cnt_q;

endmodule

// File: tb/tb_duty_phase_limiter.sv
// Randomized self-checking bench for duty_phase_limiter against a frame-level
// reference model of the clamp/wrap rules and per-frame statistics.
module tb_duty_phase_limiter;

  localparam int unsigned WIDTH = 13;
  localparam int unsigned DEPTH = 249;
  localparam int unsigned VW    = 1 + WIDTH + WIDTH + 1 + 1 + 16;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        trig = 1'b0;
  logic [DEPTH-1:0][WIDTH-1:0] cycle_v;
  logic                        din_valid = 1'b0;
  logic [WIDTH-1:0]            duty_in = '0;
  logic [WIDTH-1:0]            phase_in = '0;
  logic [WIDTH-1:0]            duty_out;
  logic [WIDTH-1:0]            phase_out;
  logic                        dout_valid;
  logic                        frame_done;
  logic                        frame_err;
  logic [15:0]                 clamp_cnt;

  duty_phase_limiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK_L(clk), .RST_N(rst_n), .TRIG_40KHZ(trig), .CYCLE(cycle_v),
    .DIN_VALID(din_valid), .DUTY_IN(duty_in), .PHASE_IN(phase_in),
    .DUTY_OUT(duty_out), .PHASE_OUT(phase_out), .DOUT_VALID(dout_valid),
    .FRAME_DONE(frame_done), .FRAME_ERR(frame_err), .CLAMP_CNT(clamp_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: frame position, statistics, visible outputs
  int m_idx, m_acc, m_clamp, m_duty, m_phase;
  logic m_valid, m_done, m_err;
  // result of the beat accepted on the previous clock, emitted on the next one
  logic p_valid, p_last, p_mod;
  int   p_duty, p_phase;
  logic [VW-1:0] exp_vec;

  function automatic logic [VW-1:0] obs();
    return {dout_valid, duty_out, phase_out, frame_done, frame_err, clamp_cnt};
  endfunction

  task automatic model_clear();
    m_idx = 0; m_acc = 0; m_clamp = 0; m_duty = 0; m_phase = 0;
    m_valid = 0; m_done = 0; m_err = 0;
    p_valid = 0; p_last = 0; p_mod = 0; p_duty = 0; p_phase = 0;
    exp_vec = '0;
  endtask

  // drive one clock of stimulus and advance the reference model by one clock
  task automatic step(input logic t, input logic v, input int d, input int p);
    int c, h, od, op;
    logic abort;
    trig = t; din_valid = v; duty_in = WIDTH'(d); phase_in = WIDTH'(p);
    @(posedge clk);
    #1;
    m_valid = p_valid;
    m_done  = 1'b0;
    if (p_valid) begin
      m_duty = p_duty; m_phase = p_phase;
      if (p_mod && m_acc < 65535) m_acc = m_acc + 1;
      if (p_last) begin m_done = 1'b1; m_clamp = m_acc; m_acc = 0; end
    end
    abort = t && (m_idx != 0);
    m_err = abort;
    if (abort) begin m_idx = 0; m_acc = 0; end
    p_valid = v; p_last = 1'b0; p_mod = 1'b0;
    if (v) begin
      c = int'(cycle_v[m_idx]);
      h = c / 2;
      od = (d < h) ? d : h;
      if (p < c) op = p;
      else if (p - c < c) op = p - c;
      else op = 0;
      if (c == 0) begin od = 0; op = 0; end
      p_duty = od; p_phase = op;
      p_mod  = (od != d) || (op != p);
      p_last = (m_idx == DEPTH - 1);
      m_idx  = (m_idx + 1) % DEPTH;
    end
    exp_vec = {m_valid, WIDTH'(m_duty), WIDTH'(m_phase), m_done, m_err, 16'(m_clamp)};
    trig = 1'b0; din_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic set_cycles(input int val);
    for (int i = 0; i < int'(DEPTH); i++) cycle_v[i] = WIDTH'(val);
  endtask

  task automatic test_reset();
    set_cycles(4096);
    rst_n = 1'b0;
    model_clear();
    #3;
    n_cmp++;
    if (obs() !== exp_vec) begin
      n_bad++; $display("FAIL reset_state: got %h want %h", obs(), exp_vec);
    end
    apply_reset();
    n_cmp++;
    if (obs() !== exp_vec) begin
      n_bad++; $display("FAIL reset_release: got %h want %h", obs(), exp_vec);
    end
  endtask

  task automatic test_first_beat();
    step(0, 1, 100, 50);
    n_cmp++;
    if (dout_valid !== 1'b0) begin
      n_bad++; $display("FAIL first_beat_early: got valid %b want 0", dout_valid);
    end
    step(0, 0, 0, 0);
    n_cmp++;
    if ({dout_valid, duty_out, phase_out} !== {1'b1, 13'd100, 13'd50}) begin
      n_bad++; $display("FAIL first_beat: got %b/%0d/%0d want 1/100/50", dout_valid, duty_out, phase_out);
    end
    n_cmp++;
    if (obs() !== exp_vec) begin
      n_bad++; $display("FAIL first_beat_model: got %h want %h", obs(), exp_vec);
    end
  endtask

  task automatic test_full_frame();
    int dones = 0;
    apply_reset();
    set_cycles(4096);
    for (int i = 0; i <= int'(DEPTH) + 1; i++) begin
      step(0, i < int'(DEPTH), 3000, 5000);
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_bad++; $display("FAIL full_frame[%0d]: got %h want %h", i, obs(), exp_vec);
      end
      if (dout_valid && (duty_out !== 13'd2048 || phase_out !== 13'd904)) begin
        n_bad++; $display("FAIL full_frame_value[%0d]: got %0d/%0d want 2048/904", i, duty_out, phase_out);
      end
      if (frame_done === 1'b1) dones++;
    end
    n_cmp++;
    if (clamp_cnt !== 16'd249 || dones != 1) begin
      n_bad++; $display("FAIL full_frame_stats: got clamp %0d dones %0d want 249 1", clamp_cnt, dones);
    end
  endtask

  task automatic test_phase_bounds();
    set_cycles(4096);
    cycle_v[3] = WIDTH'(100);
    cycle_v[4] = '0;
    for (int i = 0; i <= int'(DEPTH) + 1; i++) begin
      if (i == 3) step(0, 1, 10, 250);
      else if (i == 4) step(0, 1, 7, 10);
      else step(0, i < int'(DEPTH), 10, 10);
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_bad++; $display("FAIL phase_bounds[%0d]: got %h want %h", i, obs(), exp_vec);
      end
      if (i == 4 && phase_out !== 13'd0) begin
        n_bad++; $display("FAIL phase_wrap_zero: got %0d want 0", phase_out);
      end
      if (i == 5 && (duty_out !== 13'd0 || phase_out !== 13'd0)) begin
        n_bad++; $display("FAIL zero_cycle: got %0d/%0d want 0/0", duty_out, phase_out);
      end
    end
    n_cmp++;
    if (clamp_cnt !== 16'd2) begin
      n_bad++; $display("FAIL phase_bounds_cnt: got %0d want 2", clamp_cnt);
    end
  endtask

  task automatic randomize_cycles();
    for (int i = 0; i < int'(DEPTH); i++) begin
      case ($urandom_range(0, 7))
        0: cycle_v[i] = '0;
        1: cycle_v[i] = WIDTH'($urandom_range(1, 64));
        default: cycle_v[i] = WIDTH'($urandom_range(0, 8191));
      endcase
    end
  endtask

  task automatic test_gapped_stream();
    int beats = 0;
    int dones = 0;
    int gap;
    randomize_cycles();
    while (beats < int'(DEPTH) + 2) begin
      gap = (beats < int'(DEPTH)) ? int'($urandom_range(0, 3)) : 0;
      for (int g = 0; g <= gap; g++) begin
        if (g == gap && beats < int'(DEPTH))
          step(0, 1, int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)));
        else
          step(0, 0, 0, 0);
        n_cmp++;
        if (obs() !== exp_vec) begin
          n_bad++; $display("FAIL gapped[%0d]: got %h want %h", beats, obs(), exp_vec);
        end
        if (frame_done === 1'b1) dones++;
      end
      beats++;
    end
    n_cmp++;
    if (dones != 1) begin
      n_bad++; $display("FAIL gapped_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_trigger_abort();
    int held;
    int dones = 0;
    randomize_cycles();
    held = m_clamp;
    step(1, 0, 0, 0);
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_bad++; $display("FAIL trig_idx0: got err %b want 0", frame_err);
    end
    for (int i = 0; i < 11; i++) begin
      step(0, 1, int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)));
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_bad++; $display("FAIL abort_pre[%0d]: got %h want %h", i, obs(), exp_vec);
      end
    end
    step(1, 1, int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)));
    n_cmp++;
    if (frame_err !== 1'b1 || clamp_cnt !== 16'(held)) begin
      n_bad++; $display("FAIL abort_err: got err %b clamp %0d want 1 %0d", frame_err, clamp_cnt, held);
    end
    for (int i = 1; i <= int'(DEPTH) + 1; i++) begin
      step(0, i < int'(DEPTH), int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)));
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_bad++; $display("FAIL abort_post[%0d]: got %h want %h", i, obs(), exp_vec);
      end
      if (frame_done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 1) begin
      n_bad++; $display("FAIL abort_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_midframe_reset();
    int dones = 0;
    randomize_cycles();
    for (int i = 0; i <= 100; i++) begin
      step(0, 1, int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)));
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_bad++; $display("FAIL pre_reset[%0d]: got %h want %h", i, obs(), exp_vec);
      end
    end
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (obs() !== exp_vec) begin
      n_bad++; $display("FAIL midframe_reset: got %h want %h", obs(), exp_vec);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i <= int'(DEPTH) + 1; i++) begin
      step(0, i < int'(DEPTH), int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)));
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_bad++; $display("FAIL post_reset[%0d]: got %h want %h", i, obs(), exp_vec);
      end
      if (frame_done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 1 || clamp_cnt !== 16'(m_clamp)) begin
      n_bad++; $display("FAIL post_reset_stats: got dones %0d clamp %0d want 1 %0d", dones, clamp_cnt, m_clamp);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_first_beat();
    test_full_frame();
    test_phase_bounds();
    test_gapped_stream();
    test_trigger_abort();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/duty_phase_limiter.md
Name: duty_phase_limiter

Overview:
- Pipeline stage between the silencer output stream and the pwm block, clocked on CLK_L.
- Consumes the per-transducer duty/phase beat stream, DEPTH beats per frame.
- Clamps each duty to half of that transducer's cycle and wraps each phase into [0, cycle).
- Reports clamp statistics per frame and flags frames broken by a 40 kHz trigger arriving mid-frame.

Parameters:
WIDTH, 13, bit width of duty, phase and cycle values
DEPTH, 249, number of transducers, i.e. beats per frame

Ports:
CLK_L  in  1  pipeline clock
RST_N  in  1  asynchronous active-low reset
TRIG_40KHZ  in  1  frame boundary pulse, one CLK_L cycle wide
CYCLE  in  WIDTH x DEPTH  per-transducer cycle; quasi-static, treated as stable
DIN_VALID  in  1  input beat valid
DUTY_IN  in  WIDTH  input duty
PHASE_IN  in  WIDTH  input phase
DUTY_OUT  out  WIDTH  limited duty
PHASE_OUT  out  WIDTH  wrapped phase
DOUT_VALID  out  1  output beat valid
FRAME_DONE  out  1  one-cycle pulse coincident with the last beat of a frame on the output
FRAME_ERR  out  1  one-cycle pulse when a frame is aborted by TRIG_40KHZ
CLAMP_CNT  out  16  number of modified beats in the last completed frame

Behaviour:
Reset
- Asynchronous reset on RST_N low; release is synchronous to CLK_L.
- All outputs reset to 0.
- Beat index idx resets to 0; the clamp accumulator resets to 0; pipeline valid bits are cleared.
- Reset mid-frame discards in-flight beats. No FRAME_DONE or FRAME_ERR is emitted for that frame.

Beat indexing
- idx (ceil(log2 DEPTH) bits) advances by 1 on each cycle with DIN_VALID=1.
- After beat DEPTH-1, idx wraps to 0.
- Gaps (DIN_VALID=0) between beats are allowed and do not advance idx.

Pipeline (fixed latency of 2 cycles, no backpressure)
- S1 registers: valid, duty, phase, c = CYCLE[idx], last = (idx == DEPTH-1).
- S2 computes the limit h = c >> 1 (floor).
- Duty: DUTY_OUT = min(duty, h).
- Phase:
  - If phase < c: PHASE_OUT = phase.
  - Else if phase - c < c: PHASE_OUT = phase - c.
  - Else: PHASE_OUT = 0.
- Zero cycle: if c == 0, DUTY_OUT = 0 and PHASE_OUT = 0.
- A beat counts as modified if DUTY_OUT != duty or PHASE_OUT != phase.
- All arithmetic is unsigned WIDTH bits; the subtraction is evaluated only when phase >= c, so it never underflows.
- DOUT_VALID equals DIN_VALID delayed by 2 cycles.
- DUTY_OUT and PHASE_OUT hold their last value while DOUT_VALID=0.

Frame statistics
- The accumulator increments on each modified output beat and saturates at 16'hFFFF.
- On the output beat with last=1:
  - FRAME_DONE=1.
  - CLAMP_CNT is loaded with the accumulator value including that beat.
  - The accumulator is cleared.

Trigger resync (evaluated at S0, the input side)
- TRIG_40KHZ=1 with idx == 0: no effect.
- TRIG_40KHZ=1 with idx != 0:
  - FRAME_ERR pulses in the next cycle.
  - idx is forced to 0.
  - The accumulator is cleared and CLAMP_CNT is unchanged.
  - Beats already in S1/S2 still exit normally, but their last flag is not set, so no FRAME_DONE is produced for the aborted frame.
- Simultaneous TRIG_40KHZ and DIN_VALID with idx != 0: the incoming beat is taken as index 0 of the new frame and uses CYCLE[0].
- Simultaneous FRAME_DONE on the output and an abort on the input in the same cycle:
  - The CLAMP_CNT load takes effect.
  - The accumulator clear for the abort wins, leaving it at 0.

Test Plan:
1. Reset value: RST_N low, then released → all outputs 0. First beat DUTY_IN=100, PHASE_IN=50, CYCLE[0]=4096 → DUTY_OUT=100, PHASE_OUT=50 exactly 2 cycles later; not counted as modified.
2. Full frame: all CYCLE=4096, 249 consecutive beats with DUTY_IN=3000, PHASE_IN=5000 → every output has DUTY_OUT=2048, PHASE_OUT=904. FRAME_DONE on the 249th output beat; CLAMP_CNT=249.
3. Phase bounds: CYCLE[3]=100 with PHASE_IN=250 → PHASE_OUT=0. CYCLE[4]=0 with DUTY_IN=7 → DUTY_OUT=0, PHASE_OUT=0, counted as modified.
4. Gapped stream: 249 beats with random 0–3 cycle gaps → output order preserved, DOUT_VALID pattern equals the input pattern delayed by 2, exactly one FRAME_DONE.
5. Trigger abort: TRIG_40KHZ after beat 10 → FRAME_ERR pulse, CLAMP_CNT holds its previous value. The next 249 beats form a complete frame using CYCLE[0..248]; the trigger coincident with a beat makes that beat index 0.
6. Mid-frame reset: RST_N asserted after beat 100 → outputs immediately 0, no FRAME_DONE. The next frame starts at idx 0 and produces CLAMP_CNT only from its own beats.
